// File: rtl/sync_dual_port_ram_if.sv
// Bus bundle for sync_dual_port_ram: one write port, one read port and the
// init status. The master drives requests; the slave (the RAM) drives results.
interface sync_dual_port_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                      cs;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      rd_valid;
  logic                      init_done;

  modport master (
    output cs, wr_en, wr_addr, data_in, byte_en, rd_en, rd_addr,
    input  data_out, rd_valid, init_done
  );

  modport slave (
    input  cs, wr_en, wr_addr, data_in, byte_en, rd_en, rd_addr,
    output data_out, rd_valid, init_done
  );
endinterface

// File: rtl/sync_dual_port_ram.sv
// Simple dual-port RAM (one write port, one read port, one clock) with
// per-byte write enables, 1- or 2-cycle registered read latency, a fixed
// same-address collision policy, and a self-clearing init sequence that runs
// after every reset before any access is accepted.
module sync_dual_port_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sync_dual_port_ram_if.slave  bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   init_cnt_reg, init_cnt_next;

  // Unified write request into the lanes: either the init clear or a user write.
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_BYTES-1:0]    mem_wbe;
  logic                    rd_accept;

  // First read stage: word assembled from the per-lane read registers.
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_valid1_reg;

  // State and init counter; reset restarts the clear sequence from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  // Next state and port arbitration: INIT owns the write port and blocks reads.
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    mem_we        = 1'b0;
    mem_waddr     = bus.wr_addr;
    mem_wdata     = bus.data_in;
    mem_wbe       = bus.byte_en;
    rd_accept     = 1'b0;
    case (state_reg)
      INIT: begin
        mem_we        = 1'b1;
        mem_waddr     = init_cnt_reg;
        mem_wdata     = '0;
        mem_wbe       = '1;
        init_cnt_next = init_cnt_reg + ADDR_WIDTH'(1);
        if (&init_cnt_reg) begin
          state_next = READY;
        end
      end
      READY: begin
        mem_we    = bus.cs & bus.wr_en;
        rd_accept = bus.cs & bus.rd_en;
      end
      default: state_next = INIT;
    endcase
  end

  // One narrow memory per byte lane so byte enables map onto plain lane writes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;
      logic       lane_hit;

      // This lane is being written at the address being read in this cycle.
      assign lane_hit = mem_we && mem_wbe[gi] && (mem_waddr == bus.rd_addr);

      // Lane array write; no reset so the array stays inferable as block RAM.
      always_ff @(posedge clk) begin
        if (mem_we && mem_wbe[gi]) begin
          mem[mem_waddr] <= mem_wdata[8*gi +: 8];
        end
      end

      // Registered lane read with collision bypass; holds between reads.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_byte_reg <= '0;
        end else if (rd_accept) begin
          if ((WRITE_FIRST != 0) && lane_hit) begin
            rd_byte_reg <= mem_wdata[8*gi +: 8];
          end else begin
            rd_byte_reg <= mem[bus.rd_addr];
          end
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // Valid strobe for the first read stage; reset drops any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid1_reg <= 1'b0;
    end else begin
      rd_valid1_reg <= rd_accept;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign bus.data_out = rd_word;
      assign bus.rd_valid = rd_valid1_reg;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] data_out_reg;
      logic                  rd_valid2_reg;

      // Second output stage; data only advances when a result moves through.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_out_reg  <= '0;
          rd_valid2_reg <= 1'b0;
        end else begin
          rd_valid2_reg <= rd_valid1_reg;
          if (rd_valid1_reg) begin
            data_out_reg <= rd_word;
          end
        end
      end

      assign bus.data_out = data_out_reg;
      assign bus.rd_valid = rd_valid2_reg;
    end
  endgenerate

  assign bus.init_done = (state_reg == READY);
endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Scoreboard bench for sync_dual_port_ram. Two instances share one stimulus:
// u_wf1 (write-first, latency 1) and u_wf0 (read-first, latency 2). Each read
// pushes its hand-computed expected word and due cycle; per-instance monitors
// pop and compare whenever rd_valid is seen.
module tb_sync_dual_port_ram;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, byte_en;
  logic [31:0] data_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t m1, m0;

  always #5 clk = ~clk;

  // Edge counter used to check read latency.
  always @(posedge clk) cyc <= cyc + 1;

  sync_dual_port_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();
  sync_dual_port_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();

  assign bus1.cs = cs;       assign bus0.cs = cs;
  assign bus1.wr_en = wr_en; assign bus0.wr_en = wr_en;
  assign bus1.rd_en = rd_en; assign bus0.rd_en = rd_en;
  assign bus1.wr_addr = wr_addr; assign bus0.wr_addr = wr_addr;
  assign bus1.rd_addr = rd_addr; assign bus0.rd_addr = rd_addr;
  assign bus1.data_in = data_in; assign bus0.data_in = data_in;
  assign bus1.byte_en = byte_en; assign bus0.byte_en = byte_en;

  sync_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_FIRST(1)) u_wf1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  sync_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_FIRST(0)) u_wf0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the write-first, latency-1 instance.
  always @(negedge clk) begin
    if (bus1.rd_valid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rd_valid_wf1: got rd_valid=1 data %h, expected no result (cycle %0d)", bus1.data_out, cyc);
      end else begin
        m1 = q1.pop_front();
        $display("wf1 result cycle %0d data %h", cyc, bus1.data_out);
        chk("rd_data_wf1", bus1.data_out, m1.data);
        chk("rd_cycle_wf1", 32'(cyc), 32'(m1.due));
      end
    end else if (q1.size() != 0 && q1[0].due < cyc) begin
      m1 = q1.pop_front();
      chk("missing_rd_valid_wf1", 32'(cyc), 32'(m1.due));
    end
  end

  // Monitor for the read-first, latency-2 instance.
  always @(negedge clk) begin
    if (bus0.rd_valid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rd_valid_wf0: got rd_valid=1 data %h, expected no result (cycle %0d)", bus0.data_out, cyc);
      end else begin
        m0 = q0.pop_front();
        $display("wf0 result cycle %0d data %h", cyc, bus0.data_out);
        chk("rd_data_wf0", bus0.data_out, m0.data);
        chk("rd_cycle_wf0", 32'(cyc), 32'(m0.due));
      end
    end else if (q0.size() != 0 && q0[0].due < cyc) begin
      m0 = q0.pop_front();
      chk("missing_rd_valid_wf0", 32'(cyc), 32'(m0.due));
    end
  end

  // Drive one cycle of inputs (called at a falling edge), then wait a cycle.
  task automatic drive(input logic c, input logic w, input logic r, input logic [3:0] wa,
                       input logic [31:0] d, input logic [3:0] be, input logic [3:0] ra);
    cs = c; wr_en = w; rd_en = r; wr_addr = wa; data_in = d; byte_en = be; rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] e1, input logic [31:0] e0);
    exp_t t;
    t.data = e1; t.due = cyc + 1; q1.push_back(t);
    t.data = e0; t.due = cyc + 2; q0.push_back(t);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e0);
    $display("read  addr %0d", a);
    push(e1, e0);
    drive(1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, a);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    $display("write addr %0d data %h be %b", a, d, be);
    drive(1'b1, 1'b1, 1'b0, a, d, be, 4'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
  endtask

  // Release reset and step through the 16 init edges, optionally poking a read.
  task automatic init_seq(input bit stray_read);
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (stray_read && e == 3) begin
        $display("read  addr 3 during init (must be ignored)");
        drive(1'b1, 1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, 4'd3);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
      end
      if (e == 15) begin
        chk("init_done_edge15_wf1", 32'(bus1.init_done), 32'd0);
        chk("init_done_edge15_wf0", 32'(bus0.init_done), 32'd0);
      end
      if (e == 16) begin
        chk("init_done_edge16_wf1", 32'(bus1.init_done), 32'd1);
        chk("init_done_edge16_wf0", 32'(bus0.init_done), 32'd1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cs = 0; wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; data_in = 0; byte_en = 0;
    repeat (3) @(negedge clk);
    chk("reset_data_out_wf1", bus1.data_out, 32'd0);
    chk("reset_data_out_wf0", bus0.data_out, 32'd0);
    chk("reset_rd_valid_wf1", 32'(bus1.rd_valid), 32'd0);
    chk("reset_rd_valid_wf0", 32'(bus0.rd_valid), 32'd0);
    chk("reset_init_done_wf1", 32'(bus1.init_done), 32'd0);
    chk("reset_init_done_wf0", 32'(bus0.init_done), 32'd0);

    // Init: stray read ignored, then every location reads back as zero.
    init_seq(1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'd0, 32'd0);
    idle(3);

    // Byte enables.
    wr(4'd5, 32'hAABB_CCDD, 4'b1111);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    rd(4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
    idle(3);

    // Full-word collision at addr 7 (currently 0), then a follow-up read.
    $display("write+read addr 7 data deadbeef be 1111");
    push(32'hDEAD_BEEF, 32'h0000_0000);
    drive(1'b1, 1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'b1111, 4'd7);
    rd(4'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    // Partial collision at addr 5: only the low two bytes are replaced.
    $display("write+read addr 5 data 99887766 be 0011");
    push(32'hAA22_7766, 32'hAA22_CC44);
    drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h9988_7766, 4'b0011, 4'd5);
    rd(4'd5, 32'hAA22_7766, 32'hAA22_7766);
    // Same-cycle write and read to different addresses are independent.
    $display("write addr 6 data cafef00d + read addr 7");
    push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b1, 4'd6, 32'hCAFE_F00D, 4'b1111, 4'd7);
    rd(4'd6, 32'hCAFE_F00D, 32'hCAFE_F00D);
    idle(3);

    // Pipelined back-to-back reads including the top address.
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h10 + 32'(i), 4'b1111);
    rd(4'd15, 32'h1F, 32'h1F);
    rd(4'd0,  32'h10, 32'h10);
    rd(4'd1,  32'h11, 32'h11);
    idle(3);

    // cs gating: neither port acts while cs is low.
    $display("cs=0 write+read addr 2 data ffffffff");
    drive(1'b0, 1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'b1111, 4'd2);
    rd(4'd2, 32'h12, 32'h12);
    idle(4);
    chk("data_out_hold_wf1", bus1.data_out, 32'h12);
    chk("data_out_hold_wf0", bus0.data_out, 32'h12);

    // Reset while a read is in flight.
    wr(4'd9, 32'h55, 4'b1111);
    $display("read  addr 9 then reset before result");
    cs = 1'b1; wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd9;
    @(posedge clk);
    #1 reset = 1'b1;
    cs = 1'b0; rd_en = 1'b0;
    #1;
    chk("midreset_rd_valid_wf1", 32'(bus1.rd_valid), 32'd0);
    chk("midreset_rd_valid_wf0", 32'(bus0.rd_valid), 32'd0);
    chk("midreset_data_out_wf1", bus1.data_out, 32'd0);
    chk("midreset_data_out_wf0", bus0.data_out, 32'd0);
    chk("midreset_init_done_wf1", 32'(bus1.init_done), 32'd0);
    repeat (3) @(negedge clk);
    init_seq(1'b0);
    rd(4'd9, 32'd0, 32'd0);
    rd(4'd2, 32'd0, 32'd0);
    idle(4);

    chk("pending_results_wf1", 32'(q1.size()), 32'd0);
    chk("pending_results_wf0", 32'(q0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
